sipo_stream: RTL and testbench

- Parametrised serial-in/parallel-out deserialiser with valid/ready handshakes on both sides. It is the successor to the fixed 8-bit SIPO.
- Adds configurable word width, selectable bit order, a synchronous clear, and a one-word output holding register. Serial shifting continues while the previous word waits downstream.
- Sits between a bit-serial source (UART/SPI front end, test pattern generator) and a word-wide streaming consumer.

---
 rtl/sipo_stream_if.sv | 22 ++
 rtl/sipo_stream.sv | 75 +++++++
 tb/tb_sipo_stream.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_stream_if.sv
// Streaming handshake bundle for sipo_stream: serial input side plus word output side.
interface sipo_stream_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             serial_in;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    // master = environment (bit source + word sink), slave = the deserialiser
    modport master (
        output in_valid, serial_in, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_valid, serial_in, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/sipo_stream.sv
// Serial-in/parallel-out deserialiser with valid/ready on both sides and a
// one-word holding register so shifting continues while a word waits downstream.
module sipo_stream #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0,
    parameter int CNT_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    sipo_stream_if.slave     bus,
    output logic [CNT_W-1:0] bit_count
);

    generate
        if (WIDTH < 2) begin : g_width_check
            $error("sipo_stream: WIDTH must be at least 2");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] hold_data;
    logic             hold_valid;
    logic             last_bit;
    logic             accept;
    logic             drain;

    // Only the completing bit has to wait for the holding register to free up.
    assign last_bit    = (bit_count == LAST);
    assign bus.in_ready = !(last_bit && hold_valid && !bus.out_ready);
    assign accept      = bus.in_valid && bus.in_ready && !clear;
    assign drain       = hold_valid && bus.out_ready;

    assign bus.out_data  = hold_data;
    assign bus.out_valid = hold_valid;

    always_comb begin
        shifted = '0;
        if (LSB_FIRST) begin
            shifted = {bus.serial_in, sreg[WIDTH-1:1]};
        end else begin
            shifted = {sreg[WIDTH-2:0], bus.serial_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg      <= '0;
            bit_count <= '0;
        end else if (clear) begin
            sreg      <= '0;
            bit_count <= '0;
        end else if (accept) begin
            sreg      <= shifted;
            bit_count <= last_bit ? '0 : bit_count + CNT_W'(1);
        end
    end

    // A load on the same edge as a drain wins, giving back-to-back words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else if (accept && last_bit) begin
            hold_data  <= shifted;
            hold_valid <= 1'b1;
        end else if (drain) begin
            hold_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sipo_stream.sv
// Scoreboard bench for sipo_stream: two 8-bit instances (both bit orders) share stimulus,
// plus WIDTH=2 and WIDTH=16/LSB-first instances for width and wrap checks.
module tb_sipo_stream;

    logic clk;
    logic rst_n;
    logic clear8;

    int tests;
    int fails;

    logic [63:0] q8m[$];
    logic [63:0] q8l[$];
    logic [63:0] q2[$];
    logic [63:0] q16[$];

    logic [2:0] cnt8m;
    logic [2:0] cnt8l;
    logic [0:0] cnt2;
    logic [3:0] cnt16;

    sipo_stream_if #(.WIDTH(8))  b8m ();
    sipo_stream_if #(.WIDTH(8))  b8l ();
    sipo_stream_if #(.WIDTH(2))  b2 ();
    sipo_stream_if #(.WIDTH(16)) b16 ();

    // The LSB-first 8-bit instance mirrors every input of the MSB-first one.
    assign b8l.in_valid  = b8m.in_valid;
    assign b8l.serial_in = b8m.serial_in;
    assign b8l.out_ready = b8m.out_ready;

    sipo_stream #(.WIDTH(8), .LSB_FIRST(1'b0)) u8m (
        .clk(clk), .rst_n(rst_n), .clear(clear8), .bus(b8m), .bit_count(cnt8m));
    sipo_stream #(.WIDTH(8), .LSB_FIRST(1'b1)) u8l (
        .clk(clk), .rst_n(rst_n), .clear(clear8), .bus(b8l), .bit_count(cnt8l));
    sipo_stream #(.WIDTH(2), .LSB_FIRST(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .clear(1'b0), .bus(b2), .bit_count(cnt2));
    sipo_stream #(.WIDTH(16), .LSB_FIRST(1'b1)) u16 (
        .clk(clk), .rst_n(rst_n), .clear(1'b0), .bus(b16), .bit_count(cnt16));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    // Scoreboard monitors: a word is consumed whenever a handshake is pending.
    always @(negedge clk) begin
        if (rst_n && b8m.out_valid && b8m.out_ready) begin
            if (q8m.size() == 0) check("sb8m_unexpected_word", 64'(b8m.out_data), 64'hDEAD);
            else check("sb8m_word", 64'(b8m.out_data), q8m.pop_front());
        end
        if (rst_n && b8l.out_valid && b8l.out_ready) begin
            if (q8l.size() == 0) check("sb8l_unexpected_word", 64'(b8l.out_data), 64'hDEAD);
            else check("sb8l_word", 64'(b8l.out_data), q8l.pop_front());
        end
        if (rst_n && b2.out_valid && b2.out_ready) begin
            if (q2.size() == 0) check("sb2_unexpected_word", 64'(b2.out_data), 64'hDEAD);
            else check("sb2_word", 64'(b2.out_data), q2.pop_front());
        end
        if (rst_n && b16.out_valid && b16.out_ready) begin
            if (q16.size() == 0) check("sb16_unexpected_word", 64'(b16.out_data), 64'hDEAD);
            else check("sb16_word", 64'(b16.out_data), q16.pop_front());
        end
    end

    task automatic send_bit(input logic b);
        int n;
        n = 0;
        b8m.in_valid  = 1'b1;
        b8m.serial_in = b;
        @(negedge clk);
        while (!b8m.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!b8m.in_ready) check("send_bit_timeout", 64'(b8m.in_ready), 64'h1);
        @(posedge clk);
        #1;
    endtask

    // Sends w MSB first; the MSB-first instance rebuilds w, the LSB-first one its reverse.
    task automatic send8(input logic [7:0] w, input bit expect_it);
        if (expect_it) begin
            q8m.push_back(64'(w));
            q8l.push_back(64'(rev8(w)));
        end
        for (int k = 7; k >= 0; k--) send_bit(w[k]);
    endtask

    task automatic idle(input int n);
        b8m.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [7:0] stream_words [4];
    logic [15:0] w16;
    logic [1:0]  w2;

    initial begin
        tests = 0;
        fails = 0;
        stream_words = '{8'h1E, 8'hFF, 8'h00, 8'hA5};
        clear8 = 1'b0;
        b8m.in_valid = 1'b0; b8m.serial_in = 1'b0; b8m.out_ready = 1'b1;
        b2.in_valid = 1'b0;  b2.serial_in = 1'b0;  b2.out_ready = 1'b1;
        b16.in_valid = 1'b0; b16.serial_in = 1'b0; b16.out_ready = 1'b1;
        rst_n = 1'b0;

        // Reset state, no clock edge needed
        #2;
        check("reset_out_valid", 64'(b8m.out_valid), 64'h0);
        check("reset_out_data", 64'(b8m.out_data), 64'h0);
        check("reset_bit_count", 64'(cnt8m), 64'h0);
        check("reset_in_ready", 64'(b8m.in_ready), 64'h1);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Bit order and single-cycle valid pulse
        send8(8'h1E, 1'b1);
        b8m.in_valid = 1'b0;
        @(negedge clk);
        check("order_valid_pulse", 64'(b8m.out_valid), 64'h1);
        check("order_msb_first", 64'(b8m.out_data), 64'h1E);
        check("order_lsb_first", 64'(b8l.out_data), 64'h78);
        check("order_wrap_count", 64'(cnt8m), 64'h0);
        @(negedge clk);
        check("order_valid_drop", 64'(b8m.out_valid), 64'h0);
        idle(2);

        // Continuous streaming: no stalls, pulses every 8 cycles
        for (int w = 0; w < 4; w++) begin
            q8m.push_back(64'(stream_words[w]));
            q8l.push_back(64'(rev8(stream_words[w])));
            for (int k = 7; k >= 0; k--) begin
                b8m.in_valid  = 1'b1;
                b8m.serial_in = stream_words[w][k];
                @(negedge clk);
                check("stream_in_ready", 64'(b8m.in_ready), 64'h1);
                check("stream_bit_count", 64'(cnt8m), 64'(7 - k));
                check("stream_valid_spacing", 64'(b8m.out_valid), 64'((k == 7) && (w > 0)));
                @(posedge clk);
                #1;
            end
        end
        b8m.in_valid = 1'b0;
        @(negedge clk);
        check("stream_last_valid", 64'(b8m.out_valid), 64'h1);
        @(negedge clk);
        check("stream_last_drop", 64'(b8m.out_valid), 64'h0);
        idle(2);

        // Backpressure: only the completing bit stalls
        b8m.out_ready = 1'b0;
        send8(8'h1E, 1'b1);
        q8m.push_back(64'hFF);
        q8l.push_back(64'hFF);
        for (int k = 0; k < 7; k++) send_bit(1'b1);
        b8m.in_valid  = 1'b1;
        b8m.serial_in = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("bp_in_ready_low", 64'(b8m.in_ready), 64'h0);
            check("bp_bit_count", 64'(cnt8m), 64'h7);
            check("bp_hold_data", 64'(b8m.out_data), 64'h1E);
            check("bp_hold_valid", 64'(b8m.out_valid), 64'h1);
            @(posedge clk);
            #1;
        end
        b8m.out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_comb", 64'(b8m.in_ready), 64'h1);
        @(posedge clk);
        #1;
        b8m.out_ready = 1'b0;
        b8m.in_valid  = 1'b0;
        @(negedge clk);
        check("bp_no_bubble_valid", 64'(b8m.out_valid), 64'h1);
        check("bp_no_bubble_data", 64'(b8m.out_data), 64'hFF);
        check("bp_wrap_count", 64'(cnt8m), 64'h0);
        @(posedge clk);
        #1;
        b8m.out_ready = 1'b1;
        @(posedge clk);
        #1;
        b8m.out_ready = 1'b0;
        idle(1);

        // Clear drops the partial word but keeps the held one
        send8(8'h1E, 1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        b8m.in_valid  = 1'b1;
        b8m.serial_in = 1'b1;
        clear8 = 1'b1;
        @(negedge clk);
        check("clear_pre_count", 64'(cnt8m), 64'h3);
        @(posedge clk);
        #1;
        clear8 = 1'b0;
        b8m.in_valid = 1'b0;
        @(negedge clk);
        check("clear_bit_count", 64'(cnt8m), 64'h0);
        check("clear_hold_valid", 64'(b8m.out_valid), 64'h1);
        check("clear_hold_data", 64'(b8m.out_data), 64'h1E);
        @(posedge clk);
        #1;
        b8m.out_ready = 1'b1;
        send8(8'hA5, 1'b1);
        idle(3);

        // Async reset mid-word with a word held
        b8m.out_ready = 1'b0;
        send8(8'h3C, 1'b0);
        for (int k = 0; k < 5; k++) send_bit(1'b1);
        b8m.in_valid = 1'b0;
        @(negedge clk);
        check("rst_pre_count", 64'(cnt8m), 64'h5);
        check("rst_pre_valid", 64'(b8m.out_valid), 64'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 64'(b8m.out_valid), 64'h0);
        check("rst_async_data", 64'(b8m.out_data), 64'h0);
        check("rst_async_count", 64'(cnt8m), 64'h0);
        check("rst_async_lsb_data", 64'(b8l.out_data), 64'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        b8m.out_ready = 1'b1;
        send8(8'h5A, 1'b1);
        b8m.in_valid = 1'b0;
        @(negedge clk);
        check("rst_after_data", 64'(b8m.out_data), 64'h5A);
        idle(2);

        // WIDTH=2: bits 1,0 -> 2 and bits 0,1 -> 1
        for (int p = 0; p < 2; p++) begin
            w2 = (p == 0) ? 2'b10 : 2'b01;
            q2.push_back(64'(w2));
            for (int k = 1; k >= 0; k--) begin
                b2.in_valid  = 1'b1;
                b2.serial_in = w2[k];
                @(negedge clk);
                check("w2_bit_count", 64'(cnt2), 64'(1 - k));
                @(posedge clk);
                #1;
            end
            b2.in_valid = 1'b0;
            @(negedge clk);
            check("w2_wrap_count", 64'(cnt2), 64'h0);
            check("w2_valid", 64'(b2.out_valid), 64'h1);
            check("w2_data", 64'(b2.out_data), 64'(w2));
            @(posedge clk);
            #1;
        end

        // WIDTH=16, LSB first: 0x1234 sent LSB first rebuilds 0x1234
        w16 = 16'h1234;
        q16.push_back(64'(w16));
        for (int i = 0; i < 16; i++) begin
            b16.in_valid  = 1'b1;
            b16.serial_in = w16[i];
            @(negedge clk);
            check("w16_bit_count", 64'(cnt16), 64'(i));
            @(posedge clk);
            #1;
        end
        b16.in_valid = 1'b0;
        @(negedge clk);
        check("w16_wrap_count", 64'(cnt16), 64'h0);
        check("w16_valid", 64'(b16.out_valid), 64'h1);
        check("w16_data", 64'(b16.out_data), 64'h1234);
        idle(3);

        check("sb8m_drained", 64'(q8m.size()), 64'h0);
        check("sb8l_drained", 64'(q8l.size()), 64'h0);
        check("sb2_drained", 64'(q2.size()), 64'h0);
        check("sb16_drained", 64'(q16.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
